// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and constants for the multi-channel PWM slice.
//               dir_t      - counter direction used in centre-aligned mode
//               MODE_*     - encoding of the edge/centre mode bit
//               ch_width() - channel-select width, never below one bit
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // A single channel still needs a one-bit select port.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_multi_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_gen_if
// Description : Configuration write/commit port of the PWM generator.
//               wr_i      - duty write strobe
//               ch_i      - channel targeted by wr_i
//               duty_i    - duty value written to the channel shadow
//               commit_i  - request shadow-to-active transfer at next boundary
//               period_i  - period captured into the shadow on commit_i
//               center_i  - mode captured on commit_i (0 edge, 1 centre)
//               pending_o - commit requested but not yet applied
//               master: control logic side; slave: PWM generator side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_multi_gen_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    import pwm_pkg::*;

    localparam int CH_W = ch_width(N_CH);

    logic             wr_i;
    logic [CH_W-1:0]  ch_i;
    logic [WIDTH-1:0] duty_i;
    logic             commit_i;
    logic [WIDTH-1:0] period_i;
    logic             center_i;
    logic             pending_o;

    modport master (
        output wr_i, ch_i, duty_i, commit_i, period_i, center_i,
        input  pending_o
    );

    modport slave (
        input  wr_i, ch_i, duty_i, commit_i, period_i, center_i,
        output pending_o
    );

endinterface
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM channel: double-buffered duty and registered compare.
//               clk_i  - system clock
//               rst_i  - asynchronous active-high reset
//               wr_i   - write duty_i into the shadow duty
//               duty_i - new duty value
//               load_i - boundary apply strobe (shadow -> active)
//               cnt_i  - shared period counter
//               en_i   - run enable; low forces the output low
//               pwm_o  - registered PWM output
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             en_i,
    output logic             pwm_o
);

    logic [WIDTH-1:0] duty_sh_q,  duty_sh_d;
    logic [WIDTH-1:0] duty_act_q, duty_act_d;
    logic             pwm_q,      pwm_d;

    always_comb begin
        duty_sh_d  = duty_sh_q;
        duty_act_d = duty_act_q;
        pwm_d      = 1'b0;

        if (wr_i) begin
            duty_sh_d = duty_i;
        end
        // Loading from duty_sh_d lets a write in the applying cycle take effect.
        if (load_i) begin
            duty_act_d = duty_sh_d;
        end
        // Compare against the duty in force during this cycle, not the one
        // being loaded, so a period is never cut short.
        pwm_d = en_i & (cnt_i < duty_act_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_gen
// Description : Multi-channel PWM generator with a shared period counter,
//               edge- or centre-aligned counting and commit-synchronised
//               double-buffered updates applied at period boundaries.
//               clk_i        - system clock
//               rst_i        - asynchronous active-high reset
//               en_i         - run enable; low holds counter at 0, outputs low
//               bus          - write/commit configuration port (slave)
//               period_end_o - one-cycle pulse in the cycle where cnt is 0
//               pwm_o        - registered PWM outputs, one per channel
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    pwm_multi_gen_if.slave       bus,
    output logic                 period_end_o,
    output logic [N_CH-1:0]      pwm_o
);

    localparam int CH_W = ch_width(N_CH);

    logic [WIDTH-1:0] cnt_q,        cnt_d;
    dir_t             dir_q,        dir_d;
    logic             pending_q,    pending_d;
    logic [WIDTH-1:0] period_sh_q,  period_sh_d;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic             center_sh_q,  center_sh_d;
    logic             center_act_q, center_act_d;
    logic             period_end_q, period_end_d;

    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_run_cnt;
    dir_t             w_run_dir;
    logic             w_terminal;
    logic             w_load;
    logic [N_CH-1:0]  w_wr;

    // ------------------------------------------------------------------
    // Free-running count sequence while enabled. w_terminal marks the
    // cycle whose successor count is 0; its closing edge is a boundary.
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_inc  = cnt_q + WIDTH'(1);
        w_run_cnt  = w_cnt_inc;
        w_run_dir  = dir_q;
        w_terminal = 1'b0;

        if (center_act_q == MODE_CENTER) begin
            if (dir_q == DIR_DOWN) begin
                // Counting down always ends by wrapping from 1 to 0.
                if (cnt_q <= WIDTH'(1)) begin
                    w_run_cnt  = '0;
                    w_run_dir  = DIR_UP;
                    w_terminal = 1'b1;
                end else begin
                    w_run_cnt = cnt_q - WIDTH'(1);
                end
            end else begin
                // cnt >= P only happens for P=0 and P=1, which both wrap
                // straight back to 0 without ever turning around.
                if (cnt_q >= period_act_q) begin
                    w_run_cnt  = '0;
                    w_terminal = 1'b1;
                end else if ((w_cnt_inc == period_act_q) &&
                             (period_act_q != WIDTH'(1))) begin
                    w_run_dir = DIR_DOWN;
                end
            end
        end else begin
            w_run_dir = DIR_UP;
            if (cnt_q >= period_act_q) begin
                w_run_cnt  = '0;
                w_terminal = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow capture, commit handling and counter/direction next state.
    // A disabled block treats every edge as a boundary so commits are
    // never stalled.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        pending_d    = pending_q;
        period_sh_d  = period_sh_q;
        center_sh_d  = center_sh_q;
        period_act_d = period_act_q;
        center_act_d = center_act_q;
        period_end_d = 1'b0;
        w_load       = 1'b0;

        if (bus.commit_i) begin
            period_sh_d = bus.period_i;
            center_sh_d = bus.center_i;
        end

        w_load = (bus.commit_i | pending_q) & (~en_i | w_terminal);

        if (w_load) begin
            period_act_d = period_sh_d;
            center_act_d = center_sh_d;
            pending_d    = 1'b0;
        end else if (bus.commit_i) begin
            pending_d    = 1'b1;
        end

        // A boundary already leaves cnt at 0 and direction UP, which is
        // exactly the restart required when a new set is applied.
        if (en_i) begin
            cnt_d        = w_run_cnt;
            dir_d        = w_run_dir;
            period_end_d = w_terminal;
        end else begin
            cnt_d        = '0;
            dir_d        = DIR_UP;
            period_end_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            pending_q    <= 1'b0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            center_sh_q  <= MODE_EDGE;
            center_act_q <= MODE_EDGE;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            pending_q    <= pending_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            center_sh_q  <= center_sh_d;
            center_act_q <= center_act_d;
            period_end_q <= period_end_d;
        end
    end

    // ------------------------------------------------------------------
    // Channels. Select values that match no channel are simply dropped.
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            assign w_wr[k] = bus.wr_i & (bus.ch_i == CH_W'(k));

            pwm_channel #(
                .WIDTH (WIDTH)
            ) u_channel (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .wr_i   (w_wr[k]),
                .duty_i (bus.duty_i),
                .load_i (w_load),
                .cnt_i  (cnt_q),
                .en_i   (en_i),
                .pwm_o  (pwm_o[k])
            );
        end
    endgenerate

    assign bus.pending_o = pending_q;
    assign period_end_o  = period_end_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi_gen
// Description : Self-checking bench for pwm_multi_gen. A phase-based model
//               of the period (position within a P+1 or 2P cycle frame)
//               predicts pwm_o, period_end_o and pending_o every cycle;
//               directed scenarios pin the model with literal expectations,
//               followed by randomized configuration traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_gen;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;

    logic            clk_i;
    logic            rst_i;
    logic            en_i;
    logic            period_end_o;
    logic [N_CH-1:0] pwm_o;

    int n_vec;
    int n_err;

    pwm_multi_gen_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    pwm_multi_gen #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .bus          (bus),
        .period_end_o (period_end_o),
        .pwm_o        (pwm_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------------------------------------------------------
    // Reference model: frame position m_phase, frame length derived from
    // period and mode, count recovered from the position.
    // ---------------------------------------------------------------
    int unsigned     m_dsh  [N_CH];
    int unsigned     m_dact [N_CH];
    int unsigned     m_psh, m_pact;
    bit              m_csh, m_cact;
    bit              m_pend;
    int unsigned     m_phase;
    logic [N_CH-1:0] m_pwm;
    bit              m_pe;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_dsh[k]  = 0;
            m_dact[k] = 0;
        end
        m_psh = 0; m_pact = 0; m_csh = 0; m_cact = 0;
        m_pend = 0; m_phase = 0; m_pwm = '0; m_pe = 0;
    endtask

    task automatic model_step();
        int unsigned p, len, cnt;
        bit term, apply;
        p = m_pact;
        if (p == 0)      len = 1;
        else if (m_cact) len = 2 * p;
        else             len = p + 1;
        cnt  = (m_cact && m_phase > p) ? (2 * p - m_phase) : m_phase;
        term = (m_phase == len - 1);

        for (int k = 0; k < N_CH; k++) m_pwm[k] = en_i && (cnt < m_dact[k]);
        m_pe = en_i && term;

        if (bus.wr_i && (int'(bus.ch_i) < N_CH)) m_dsh[bus.ch_i] = bus.duty_i;
        if (bus.commit_i) begin
            m_psh = bus.period_i;
            m_csh = bus.center_i;
        end
        apply = (bus.commit_i || m_pend) && (!en_i || term);
        if (apply) begin
            for (int k = 0; k < N_CH; k++) m_dact[k] = m_dsh[k];
            m_pact = m_psh;
            m_cact = m_csh;
            m_pend = 0;
        end else if (bus.commit_i) begin
            m_pend = 1;
        end
        m_phase = (!en_i || term) ? 0 : m_phase + 1;
    endtask

    initial model_reset();

    // Per-cycle comparison against the model, 1 time unit after the edge.
    always begin
        @(posedge clk_i);
        if (rst_i) model_reset();
        else       model_step();
        #1;
        check("pwm_o",        pwm_o,         m_pwm);
        check("period_end_o", period_end_o,  m_pe);
        check("pending_o",    bus.pending_o, m_pend);
    end

    // ---------------------------------------------------------------
    // Stimulus helpers (all driving happens at the falling edge)
    // ---------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic drive(input bit wr, input int ch, input int duty,
                         input bit commit, input int period, input bit center);
        bus.wr_i     = wr;
        bus.ch_i     = 2'(ch);
        bus.duty_i   = 8'(duty);
        bus.commit_i = commit;
        bus.period_i = 8'(period);
        bus.center_i = center;
        tick(1);
        bus.wr_i     = 1'b0;
        bus.commit_i = 1'b0;
    endtask

    task automatic wait_pe(input string name);
        int found;
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            tick(1);
            if (period_end_o === 1'b1) found = 1;
        end
        check(name, found, 1);
    endtask

    task automatic sample(input int ch, input int n, output int hi, output int pe, output int pat);
        hi = 0; pe = 0; pat = 0;
        for (int i = 0; i < n; i++) begin
            hi  += int'(pwm_o[ch]);
            pe  += int'(period_end_o);
            pat  = (pat << 1) | int'(pwm_o[ch]);
            tick(1);
        end
    endtask

    initial begin
        int hi, pe, pat;
        n_vec = 0;
        n_err = 0;
        rst_i = 1'b1;
        en_i  = 1'b0;
        bus.wr_i = 1'b0; bus.ch_i = '0; bus.duty_i = '0;
        bus.commit_i = 1'b0; bus.period_i = '0; bus.center_i = 1'b0;
        tick(3);
        check("rst_pwm",        pwm_o,         0);
        check("rst_period_end", period_end_o,  0);
        check("rst_pending",    bus.pending_o, 0);
        rst_i = 1'b0;
        tick(1);

        // Edge mode, P=9, D0=3 committed while disabled.
        drive(1, 0, 3, 1, 9, 0);
        check("t1_no_pending", bus.pending_o, 0);
        en_i = 1'b1;
        wait_pe("t1_wait_pe");
        sample(0, 10, hi, pe, pat);
        check("t1_high_cycles", hi, 3);
        check("t1_pe_per_10",   pe, 1);
        check("t1_pe_again",    period_end_o, 1);

        // Boundary duties: 0 low, 10 and 200 above P stay high.
        drive(1, 1, 0,   0, 0, 0);
        drive(1, 2, 10,  0, 0, 0);
        drive(1, 3, 200, 1, 9, 0);
        check("t2_pending", bus.pending_o, 1);
        wait_pe("t2_wait_pe");
        check("t2_pending_clr", bus.pending_o, 0);
        tick(1);
        sample(1, 10, hi, pe, pat);  check("t2_ch1_low",  hi, 0);
        tick(10);
        sample(2, 10, hi, pe, pat);  check("t2_ch2_high", hi, 10);
        tick(10);
        sample(3, 10, hi, pe, pat);  check("t2_ch3_high", hi, 10);

        // Mid-period update at cnt=4: no runt, new duty next period.
        wait_pe("t3_wait_pe");
        tick(4);
        drive(1, 0, 6, 1, 9, 0);
        check("t3_pending", bus.pending_o, 1);
        sample(0, 5, hi, pe, pat);
        check("t3_no_runt",      hi, 0);
        check("t3_pe_boundary",  period_end_o, 1);
        check("t3_pending_clr",  bus.pending_o, 0);
        tick(1);
        sample(0, 10, hi, pe, pat);
        check("t3_new_high", hi, 6);

        // Centre mode, P=4, D=2: 8-cycle period, 3 contiguous high cycles.
        drive(1, 0, 2, 1, 4, 1);
        wait_pe("t4_wait_apply");
        wait_pe("t4_wait_pe");
        sample(0, 8, hi, pe, pat);
        check("t4_pattern",   pat, 32'hE0);
        check("t4_pe_per_8",  pe, 1);
        check("t4_pe_again",  period_end_o, 1);

        // Commit exactly in the terminal cycle of an edge-mode P=9 frame.
        drive(0, 0, 0, 1, 9, 0);
        wait_pe("t5_wait_apply");
        tick(9);
        drive(1, 0, 5, 1, 9, 0);
        check("t5_pending_never", bus.pending_o, 0);
        check("t5_pe",            period_end_o, 1);
        tick(1);
        sample(0, 10, hi, pe, pat);
        check("t5_high", hi, 5);

        // Asynchronous reset mid-period while the output is high.
        wait_pe("t6_wait_pe");
        tick(5);
        check("t6_pre_high", pwm_o[0], 1);
        rst_i = 1'b1;
        #1;
        check("t6_async_pwm", pwm_o, 0);
        check("t6_async_pe",  period_end_o, 0);
        tick(2);
        rst_i = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            hi += (pwm_o != '0) ? 1 : 0;
        end
        check("t6_after_rst_low", hi, 0);

        // Randomized configuration traffic.
        for (int i = 0; i < 3000; i++) begin
            en_i         = ($urandom_range(0, 19) != 0);
            bus.wr_i     = ($urandom_range(0, 2) == 0);
            bus.ch_i     = 2'($urandom_range(0, 3));
            bus.duty_i   = 8'($urandom_range(0, 15));
            bus.commit_i = ($urandom_range(0, 24) == 0);
            bus.period_i = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(0, 255))
                                                        : 8'($urandom_range(0, 13));
            bus.center_i = 1'($urandom_range(0, 1));
            tick(1);
        end
        bus.wr_i = 1'b0;
        bus.commit_i = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
